sprite: RTL and testbench
=========================

SPRITE -- requirements
Module: sprite

Interface
REQ-001 Parameters: WIDTH, 8, sprite line width in pixels (data_in width) | HEIGHT, 8, lines per sprite | SCALE_X, 1, horizontal enlargement factor | SCALE_Y, 1, vertical enlargement factor | LSB, 1, 1 = bit 0 leftmost, 0 = bit WIDTH-1 leftmost | CORDW, 16, signed coordinate width | ADDRW, 6, pos width.
REQ-002 Ports SHALL be:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin drawing a sprite (one-cycle pulse at the start of the first sprite scanline).
- dma_avail  in  1  memory slot granted this cycle; pos is sampled externally.
- sx  in  CORDW signed  current horizontal screen position.
- sprx  in  CORDW signed  sprite left edge.
- data_in  in  WIDTH  sprite line data, valid one cycle after the dma_avail cycle.
- pos  out  ADDRW  sprite line index (0..HEIGHT-1) to fetch.
- pix  out  1  sprite pixel (1 = opaque).
- drawing  out  1  high while the sprite emits pixels.
- done  out  1  one-cycle completion pulse.

Function
REQ-003 FSM states SHALL be IDLE, START, AWAIT_DMA, AWAIT_DATA, AWAIT_POS, DRAW, NEXT_LINE, DONE; one transition per clock.
REQ-004 Transitions SHALL be: IDLE->START on start; START->AWAIT_DMA; AWAIT_DMA->AWAIT_DATA when dma_avail, else hold; AWAIT_DATA->AWAIT_POS; AWAIT_POS->DRAW when sx == sprx-1, else hold; DRAW->NEXT_LINE after last pixel of a non-final line; DRAW->DONE after last pixel of the final line; NEXT_LINE->AWAIT_DMA; DONE->IDLE.
REQ-005 START SHALL clear oy, cnt_y and pos; AWAIT_POS SHALL clear ox and cnt_x.
REQ-006 In AWAIT_DATA, data_in SHALL be captured into an internal WIDTH-bit line register.
REQ-007 In DRAW, cnt_x SHALL count 0..SCALE_X-1; at SCALE_X-1 (or always when SCALE_X <= 1) ox SHALL increment and cnt_x clear.
REQ-008 Last pixel SHALL be ox == WIDTH-1 with cnt_x == SCALE_X-1 (or SCALE_X <= 1); each line occupies exactly WIDTH*SCALE_X DRAW cycles.
REQ-009 In NEXT_LINE, cnt_y SHALL count 0..SCALE_Y-1; at SCALE_Y-1 (or SCALE_Y <= 1) oy and pos SHALL increment and cnt_y clear; otherwise the same line is refetched and redrawn.
REQ-010 Final line SHALL be oy == HEIGHT-1 with cnt_y == SCALE_Y-1 (or SCALE_Y <= 1); a sprite spans HEIGHT*SCALE_Y scanlines.
REQ-011 pix SHALL be combinational: in DRAW, line[ox] if LSB = 1, else line[WIDTH-1-ox]; 0 in every other state.
REQ-012 First pixel SHALL appear in the cycle where sx == sprx; the sx == sprx-1 compare SHALL be signed at CORDW bits.
REQ-013 drawing SHALL equal (state == DRAW); done SHALL equal (state == DONE).
REQ-014 pos SHALL be registered and equal oy.
REQ-015 start outside IDLE SHALL be ignored unless SPRITE_RESTART_EN is defined.
REQ-016 Counter widths SHALL be max(1, clog2(N)) so SCALE_X = 1, SCALE_Y = 1 and WIDTH = 1 synthesise.

Reset
REQ-017 rst low SHALL immediately force IDLE and clear ox, oy, cnt_x, cnt_y, line register and pos; pix, drawing and done SHALL read 0.
REQ-018 Reset mid-draw SHALL abort without a done pulse; after release the block SHALL wait for a new start.

Configuration
REQ-019 With SPRITE_RESTART_EN defined, start in any non-IDLE state SHALL force START next cycle; in-progress drawing is abandoned, with no done pulse.
REQ-020 With SPRITE_RESTART_EN undefined, start SHALL be honoured only in IDLE.

Verification
REQ-021 WIDTH=8, HEIGHT=8, SCALE=1, LSB=0, sprx=100, data_in=0xA5 -> pix at sx 100..107 = 1,0,1,0,0,1,0,1; pix 0 at sx 99 and 108.
REQ-022 Same with LSB=1, data_in=0x01 -> pix = 1 only at sx 100.
REQ-023 SCALE_X=8, data_in=0x80, LSB=0 -> pix high for sx 100..107; drawing high for 64 cycles.
REQ-024 SCALE_Y=2, one dma_avail per line -> pos sequence 0,0,1,1,..,7,7; done pulses once after 16 scanlines.
REQ-025 dma_avail held low 20 cycles after start -> state stays AWAIT_DMA, pix = 0; drawing starts only after the grant.
REQ-026 rst low during DRAW -> pix, drawing, pos = 0 at once, no done; new start draws normally; start mid-draw restarts only with SPRITE_RESTART_EN.

Source files
------------

// File: rtl/sprite.sv
// Scanline sprite renderer: fetches one sprite line per scanline through a DMA slot and
// emits pixels from sprx onward with integer X/Y scaling. Option: SPRITE_RESTART_EN.
module sprite #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned HEIGHT  = 8,
  parameter int unsigned SCALE_X = 1,
  parameter int unsigned SCALE_Y = 1,
  parameter int unsigned LSB     = 1,
  parameter int unsigned CORDW   = 16,
  parameter int unsigned ADDRW   = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    dma_avail,
  input  logic signed [CORDW-1:0] sx,
  input  logic signed [CORDW-1:0] sprx,
  input  logic [WIDTH-1:0]        data_in,
  output logic [ADDRW-1:0]        pos,
  output logic                    pix,
  output logic                    drawing,
  output logic                    done
);

  localparam int unsigned OXW = (WIDTH   > 1) ? $clog2(WIDTH)   : 1;
  localparam int unsigned OYW = (HEIGHT  > 1) ? $clog2(HEIGHT)  : 1;
  localparam int unsigned CXW = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
  localparam int unsigned CYW = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;

  typedef enum logic [2:0] {
    IDLE, START, AWAIT_DMA, AWAIT_DATA, AWAIT_POS, DRAW, NEXT_LINE, DONE
  } state_t;

  state_t                  state;
  logic [OXW-1:0]          ox;
  logic [OYW-1:0]          oy;
  logic [CXW-1:0]          cnt_x;
  logic [CYW-1:0]          cnt_y;
  logic [WIDTH-1:0]        line_buf;
  logic signed [CORDW-1:0] sprx_m1;
  logic [OXW-1:0]          px_idx;
  logic                    x_step;
  logic                    y_step;
  logic                    last_px;
  logic                    last_line;
  logic                    restart;

  // One cycle early so the first pixel lands exactly on sx == sprx
  assign sprx_m1   = sprx - CORDW'(1);
  assign x_step    = (SCALE_X <= 1) || (cnt_x == CXW'(SCALE_X - 1));
  assign y_step    = (SCALE_Y <= 1) || (cnt_y == CYW'(SCALE_Y - 1));
  assign last_px   = x_step && (ox == OXW'(WIDTH - 1));
  assign last_line = y_step && (oy == OYW'(HEIGHT - 1));

`ifdef SPRITE_RESTART_EN
  assign restart = start && (state != IDLE);
`else
  assign restart = 1'b0;
`endif

  assign px_idx  = (LSB == 1) ? ox : (OXW'(WIDTH - 1) - ox);
  assign drawing = (state == DRAW);
  assign done    = (state == DONE);

  always_comb begin
    pix = 1'b0;
    if (state == DRAW) pix = line_buf[px_idx];
  end

  // Sequencer: fetch, align to sprx, draw scaled line, repeat per scanline
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ox       <= '0;
      oy       <= '0;
      cnt_x    <= '0;
      cnt_y    <= '0;
      line_buf <= '0;
      pos      <= '0;
    end else if (restart) begin
      state <= START;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= START;
        end
        START: begin
          oy    <= '0;
          cnt_y <= '0;
          pos   <= '0;
          state <= AWAIT_DMA;
        end
        AWAIT_DMA: begin
          if (dma_avail) state <= AWAIT_DATA;
        end
        AWAIT_DATA: begin
          line_buf <= data_in;
          state    <= AWAIT_POS;
        end
        AWAIT_POS: begin
          ox    <= '0;
          cnt_x <= '0;
          if (sx == sprx_m1) state <= DRAW;
        end
        DRAW: begin
          if (x_step) begin
            ox    <= ox + OXW'(1);
            cnt_x <= '0;
          end else begin
            cnt_x <= cnt_x + CXW'(1);
          end
          if (last_px) state <= last_line ? DONE : NEXT_LINE;
        end
        NEXT_LINE: begin
          // Vertical scaling refetches the same line until cnt_y wraps
          if (y_step) begin
            oy    <= oy + OYW'(1);
            pos   <= ADDRW'(oy + OYW'(1));
            cnt_y <= '0;
          end else begin
            cnt_y <= cnt_y + CYW'(1);
          end
          state <= AWAIT_DMA;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite.sv
// Self-checking bench for sprite: three parameterisations share one stimulus stream and are
// compared per cycle against a scanline-level model of where each scaled pixel should land.
`timescale 1ns/1ps
module tb_sprite;

  localparam int NONE = -1000;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               dma_avail;
  logic signed [15:0] sx;
  logic signed [15:0] sprx;
  logic [7:0]         data_a;
  logic [7:0]         data_b;
  logic [5:0]         pos_o  [3];
  logic               pix_o  [3];
  logic               drw_o  [3];
  logic               done_o [3];

  sprite #(.WIDTH(8), .HEIGHT(8), .SCALE_X(1), .SCALE_Y(1), .LSB(0), .CORDW(16), .ADDRW(6)) u0 (
    .clk(clk), .rst(rst), .start(start), .dma_avail(dma_avail), .sx(sx), .sprx(sprx),
    .data_in(data_a), .pos(pos_o[0]), .pix(pix_o[0]), .drawing(drw_o[0]), .done(done_o[0]));
  sprite #(.WIDTH(8), .HEIGHT(8), .SCALE_X(1), .SCALE_Y(1), .LSB(1), .CORDW(16), .ADDRW(6)) u1 (
    .clk(clk), .rst(rst), .start(start), .dma_avail(dma_avail), .sx(sx), .sprx(sprx),
    .data_in(data_a), .pos(pos_o[1]), .pix(pix_o[1]), .drawing(drw_o[1]), .done(done_o[1]));
  sprite #(.WIDTH(8), .HEIGHT(8), .SCALE_X(8), .SCALE_Y(2), .LSB(0), .CORDW(16), .ADDRW(6)) u2 (
    .clk(clk), .rst(rst), .start(start), .dma_avail(dma_avail), .sx(sx), .sprx(sprx),
    .data_in(data_b), .pos(pos_o[2]), .pix(pix_o[2]), .drawing(drw_o[2]), .done(done_o[2]));

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  mem [8];
  bit          run_active;
  bit          chk_en;
  int          sprx_i;
  logic [9:0]  cap0, cap1;
  logic [15:0] cap2;
  int          dcnt0, dcnt2;
  int          done_cnt [3];

  typedef struct {
    logic [7:0]  data;
    int          sprx;
    logic [7:0]  e0;
    logic [7:0]  e1;
    logic [15:0] e2;
    int          draw0;
    int          draw2;
  } vec_t;

  function automatic int sxp(input int n); return (n == 2) ? 8 : 1; endfunction
  function automatic int syp(input int n); return (n == 2) ? 2 : 1; endfunction
  function automatic bit lsbp(input int n); return (n == 1); endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // One screen scanline: sx sweeps from sprx-pre, one DMA grant at i_dma, data valid the cycle after
  task automatic scan_line(input int k, input int pre, input int i_dma, input bit do_start,
                           input int mid_j, input int rst_j);
    int len;
    len = pre + 70;
    for (int i = 0; i < len; i++) begin
      int j;
      j = i - pre;
      @(posedge clk); #1;
      rst       = 1'b1;
      start     = (do_start && i == 0) || (j == mid_j);
      dma_avail = (i == i_dma);
      sx        = 16'(sprx_i - pre + i);
      if (i == i_dma + 1) begin
        data_a = (k < 8) ? mem[k] : 8'($urandom);
        data_b = mem[(k / 2) % 8];
      end else begin
        data_a = 8'($urandom);
        data_b = 8'($urandom);
      end
      if (j == rst_j) begin
        #2 rst = 1'b0;
        #1;
        for (int n = 0; n < 3; n++) begin
          cmp($sformatf("u%0d reset pix", n), 32'(pix_o[n]), 32'd0);
          cmp($sformatf("u%0d reset drawing", n), 32'(drw_o[n]), 32'd0);
          cmp($sformatf("u%0d reset done", n), 32'(done_o[n]), 32'd0);
          cmp($sformatf("u%0d reset pos", n), 32'(pos_o[n]), 32'd0);
        end
        run_active = 1'b0;
      end
      @(negedge clk);
      for (int n = 0; n < 3; n++) done_cnt[n] += int'(done_o[n]);
`ifdef SPRITE_RESTART_EN
      if (j == mid_j + 1) begin
        for (int n = 0; n < 3; n++)
          cmp($sformatf("u%0d restart drawing", n), 32'(drw_o[n]), 32'd0);
        chk_en = 1'b0;
      end
`endif
      if (chk_en) begin
        for (int n = 0; n < 3; n++) begin
          int nl, span, lidx;
          bit act, e_draw, e_pix, e_done;
          logic [7:0] v;
          nl     = 8 * syp(n);
          span   = 8 * sxp(n);
          act    = run_active && (k < nl);
          lidx   = (k / syp(n)) % 8;
          e_draw = act && j >= 0 && j < span;
          e_pix  = 1'b0;
          if (e_draw) begin
            v     = mem[lidx];
            e_pix = lsbp(n) ? v[j / sxp(n)] : v[7 - j / sxp(n)];
          end
          e_done = act && (k == nl - 1) && (j == span);
          cmp($sformatf("u%0d pix k%0d j%0d", n, k, j), 32'(pix_o[n]), 32'(e_pix));
          cmp($sformatf("u%0d drawing k%0d j%0d", n, k, j), 32'(drw_o[n]), 32'(e_draw));
          cmp($sformatf("u%0d done k%0d j%0d", n, k, j), 32'(done_o[n]), 32'(e_done));
          if (act && (k > 0 || i >= 2) && j < span)
            cmp($sformatf("u%0d pos k%0d j%0d", n, k, j), 32'(pos_o[n]), 32'(lidx));
        end
        if (k == 0) begin
          if (j >= -1 && j <= 8) begin
            cap0[8 - j] = pix_o[0];
            cap1[8 - j] = pix_o[1];
          end
          if (j >= 0 && j < 16) cap2[15 - j] = pix_o[2];
          dcnt0 += int'(drw_o[0]);
          dcnt2 += int'(drw_o[2]);
        end
      end
    end
  endtask

  // Full sprite: 16 scanlines (covers the 2x vertically scaled instance)
  task automatic run_sprite(input int pre, input int sprx_v, input bit mid,
                            input int rst_k, input int rst_j, input int dma0);
    sprx_i     = sprx_v;
    sprx       = 16'(sprx_v);
    run_active = 1'b1;
    chk_en     = 1'b1;
    cap0 = '0; cap1 = '0; cap2 = '0;
    dcnt0 = 0; dcnt2 = 0;
    for (int n = 0; n < 3; n++) done_cnt[n] = 0;
    for (int k = 0; k < 16; k++) begin
      int idma;
      idma = (k == 0 && dma0 > 0) ? dma0 : int'($urandom_range(pre - 3, 2));
      scan_line(k, pre, idma, k == 0, (mid && k == 3) ? 2 : NONE, (k == rst_k) ? rst_j : NONE);
    end
    if (chk_en)
      for (int n = 0; n < 3; n++)
        cmp($sformatf("u%0d done pulses", n), 32'(done_cnt[n]), (rst_k < 0) ? 32'd1 : 32'd0);
  endtask

  task automatic rand_mem();
    for (int r = 0; r < 8; r++) mem[r] = 8'($urandom);
  endtask

  initial begin
    vec_t tbl [4];
    tbl[0] = '{8'hA5, 100,  8'hA5, 8'hA5, 16'hFF00, 8, 64};
    tbl[1] = '{8'h01, 100,  8'h01, 8'h80, 16'h0000, 8, 64};
    tbl[2] = '{8'h80, 100,  8'h80, 8'h01, 16'hFF00, 8, 64};
    tbl[3] = '{8'h3C, -3,   8'h3C, 8'h3C, 16'h0000, 8, 64};

    rst = 1'b0; start = 1'b0; dma_avail = 1'b0;
    sx = '0; sprx = '0; data_a = '0; data_b = '0;
    #1;
    for (int n = 0; n < 3; n++) begin
      cmp($sformatf("u%0d por pix", n), 32'(pix_o[n]), 32'd0);
      cmp($sformatf("u%0d por drawing", n), 32'(drw_o[n]), 32'd0);
      cmp($sformatf("u%0d por done", n), 32'(done_o[n]), 32'd0);
      cmp($sformatf("u%0d por pos", n), 32'(pos_o[n]), 32'd0);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    for (int t = 0; t < 4; t++) begin
      for (int r = 0; r < 8; r++) mem[r] = tbl[t].data;
      run_sprite(12, tbl[t].sprx, 1'b0, -1, NONE, 0);
      cmp($sformatf("vec%0d u0 pixel row", t), 32'(cap0), 32'({1'b0, tbl[t].e0, 1'b0}));
      cmp($sformatf("vec%0d u1 pixel row", t), 32'(cap1), 32'({1'b0, tbl[t].e1, 1'b0}));
      cmp($sformatf("vec%0d u2 pixel row", t), 32'(cap2), 32'(tbl[t].e2));
      cmp($sformatf("vec%0d u0 draw cycles", t), 32'(dcnt0), 32'(tbl[t].draw0));
      cmp($sformatf("vec%0d u2 draw cycles", t), 32'(dcnt2), 32'(tbl[t].draw2));
    end

    // Grant withheld 23 cycles after AWAIT_DMA is reached
    rand_mem();
    run_sprite(40, 100, 1'b0, -1, NONE, 25);

    // Reset in the middle of line 2 drawing, then a normal sprite
    rand_mem();
    run_sprite(12, 50, 1'b0, 2, 3, 0);
    rand_mem();
    run_sprite(12, 50, 1'b0, -1, NONE, 0);

    // start pulsed mid-draw
    rand_mem();
    run_sprite(12, 77, 1'b1, -1, NONE, 0);

    for (int r = 0; r < 6; r++) begin
      rand_mem();
      run_sprite(int'($urandom_range(20, 8)), int'($urandom_range(500, 0)) - 200, 1'b0, -1, NONE, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
